sipo_deserializer: RTL

Serial-in parallel-out receiver for the dual-rail bit stream produced by our parallel-to-serial transmitter. Accepts one dual-rail coded bit per valid/ready handshake, LSB first, assembles `DATAWIDTH` bits into a word, and presents the word on a valid/ready output. A shift register plus a one-word output register let the next word be received while the previous one waits for downstream.

---
 rtl/sipo_pkg.sv | 8 +
 rtl/sipo_deserializer_decode.sv | 15 +
 rtl/sipo_deserializer.sv | 92 +++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared FSM state type and dual-rail code constants for the SIPO receiver.
package sipo_pkg;
  typedef enum logic {FILL, FULL} sipo_state_e;
  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ONE     = 2'b01;
  localparam logic [1:0] DR_ZERO    = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;
endpackage

// File: rtl/sipo_deserializer_decode.sv
// dual_rail_decode: classifies one dual-rail code; bit_val_o is code[0], so 11 reads as 1.
module dual_rail_decode
  import sipo_pkg::*;
(
  input  logic [1:0] code_i,
  output logic       bit_val_o,
  output logic       is_bit_o,
  output logic       is_null_o,
  output logic       is_illegal_o
);
  assign bit_val_o    = code_i[0];
  assign is_bit_o     = (code_i == DR_ONE) || (code_i == DR_ZERO);
  assign is_null_o    = code_i == DR_NULL;
  assign is_illegal_o = code_i == DR_ILLEGAL;
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: dual-rail serial-in, word-parallel-out receiver with one word of output slack.
// Optional sticky illegal-code flag err_o when SIPO_ERR_CHECK_EN is defined.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SIPO_ERR_CHECK_EN
  output logic                 err_o,
`endif
  input  logic                 din_valid_i,
  output logic                 din_ready_o,
  input  logic [1:0]           din_data_i,
  output logic                 dout_valid_o,
  input  logic                 dout_ready_i,
  output logic [DATAWIDTH-1:0] dout_data_o
);
  localparam int CW = $clog2(DATAWIDTH + 1);
  sipo_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] sr_q, sr_d, out_q, out_d, word;
  logic ov_q, ov_d;
  logic bit_val, is_bit, is_null, is_illegal;
  logic hs, take, drain;
  logic unused_dec;
  dual_rail_decode u_dec (
    .code_i      (din_data_i),
    .bit_val_o   (bit_val),
    .is_bit_o    (is_bit),
    .is_null_o   (is_null),
    .is_illegal_o(is_illegal)
  );
  assign unused_dec   = is_bit ^ is_null ^ is_illegal;
  assign din_ready_o  = state_q == FILL;
  assign dout_valid_o = ov_q;
  assign dout_data_o  = out_q;
  assign hs           = din_valid_i && din_ready_o;
  assign drain        = ov_q && dout_ready_i;
  assign word         = {bit_val, sr_q[DATAWIDTH-1:1]};
`ifdef SIPO_ERR_CHECK_EN
  logic err_q;
  assign take  = hs && is_bit;
  assign err_o = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | (hs & is_illegal);
`else
  assign take = hs && !is_null;
`endif
  // Shifting in at the MSB leaves the first bit at index 0 once the word is complete.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = take ? word : sr_q;
    out_d   = out_q;
    ov_d    = drain ? 1'b0 : ov_q;
    if (state_q == FULL) begin
      if (drain) begin
        out_d   = sr_q;
        ov_d    = 1'b1;
        cnt_d   = '0;
        state_d = FILL;
      end
    end else if (take) begin
      if (cnt_q != CW'(DATAWIDTH - 1)) cnt_d = cnt_q + 1'b1;
      else if (!ov_q || drain) begin
        out_d = word;
        ov_d  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d   = CW'(DATAWIDTH);
        state_d = FULL;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sr_q    <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
endmodule
